multi_channel_watchdog: RTL and testbench

Parametrised N-channel watchdog, the next generation of the single-channel watchdog timer used to supervise the AM radio host link and other firmware tasks. Each channel has a runtime-programmable timeout, a warning threshold, an optional window (too-early heartbeat) check and a triggered flag. A registered global escalation output is raised when enough channels have faulted. It sits between the host/CPU heartbeat sources and the system reset / RF-mute logic.

---
 rtl/multi_channel_watchdog_if.sv | 32 +++
 rtl/multi_channel_watchdog.sv | 164 ++++++++++++++++
 tb/tb_multi_channel_watchdog.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_watchdog_if.sv
// Heartbeat, configuration and status bundle of the multi-channel watchdog.
interface multi_channel_watchdog_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] heartbeat;
    logic [NUM_CH-1:0] force_reset;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_timeout;
    logic [CNT_W-1:0]  cfg_window;
    logic [NUM_CH-1:0] triggered;
    logic [NUM_CH-1:0] warning;
    logic [NUM_CH-1:0] early_err;
    logic              escalate;
    logic              any_triggered;

    // Heartbeat sources and the configuring host
    modport master (
        output enable, heartbeat, force_reset, cfg_we, cfg_ch, cfg_timeout, cfg_window,
        input  triggered, warning, early_err, escalate, any_triggered
    );

    // The watchdog itself
    modport slave (
        input  enable, heartbeat, force_reset, cfg_we, cfg_ch, cfg_timeout, cfg_window,
        output triggered, warning, early_err, escalate, any_triggered
    );
endinterface

// File: rtl/multi_channel_watchdog.sv
// N-channel watchdog: per-channel programmable timeout, warning threshold,
// optional too-early window check, and a registered global escalation.
module multi_channel_watchdog #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned DEFAULT_TIMEOUT = 625_000_000,
    parameter int unsigned WARN_SHIFT      = 2,
    parameter bit          WINDOW_EN       = 1'b0,
    parameter int unsigned ESC_THRESHOLD   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    multi_channel_watchdog_if.slave bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned POP_W = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] DEF_TO = CNT_W'(DEFAULT_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [NUM_CH-1:0] w_trig_vec;
    logic [NUM_CH-1:0] w_warn_vec;
    logic [NUM_CH-1:0] w_early_vec;
    logic [POP_W-1:0]  w_pop;
    logic              w_esc_nxt;
    logic              w_any_nxt;
    logic              r_escalate;
    logic              r_any;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_timeout;
        logic [CNT_W-1:0] r_window;
        logic             r_trig;
        logic             r_warn;
        logic             r_early;

        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_timeout_nxt;
        logic [CNT_W-1:0] w_window_nxt;
        logic             w_trig_nxt;
        logic             w_warn_nxt;
        logic             w_early_nxt;
        logic [CNT_W-1:0] w_warn_thr;
        logic [CNT_W-1:0] w_cfg_to;
        logic             w_cfg_hit;
        logic             w_early_hb;

        // Subtracting a right-shifted copy can never underflow
        assign w_warn_thr = r_timeout - (r_timeout >> WARN_SHIFT);
        // Out-of-range channel numbers simply match no channel
        assign w_cfg_hit  = bus.cfg_we && (bus.cfg_ch == CH_W'(g));
        assign w_cfg_to   = (bus.cfg_timeout == '0) ? ONE : bus.cfg_timeout;
        assign w_early_hb = WINDOW_EN && (r_cnt < r_window);

        // Next state, highest-priority event first
        always_comb begin
            w_cnt_nxt     = r_cnt;
            w_timeout_nxt = r_timeout;
            w_window_nxt  = r_window;
            w_trig_nxt    = r_trig;
            w_warn_nxt    = r_warn;
            w_early_nxt   = r_early;
            if (!bus.enable[g] || bus.force_reset[g]) begin
                w_cnt_nxt   = '0;
                w_trig_nxt  = 1'b0;
                w_warn_nxt  = 1'b0;
                w_early_nxt = 1'b0;
            end else if (w_cfg_hit) begin
                w_timeout_nxt = w_cfg_to;
                w_window_nxt  = (bus.cfg_window >= w_cfg_to) ? '0 : bus.cfg_window;
                w_cnt_nxt     = '0;
                w_trig_nxt    = 1'b0;
                w_warn_nxt    = 1'b0;
            end else if (bus.heartbeat[g]) begin
                w_cnt_nxt = '0;
                if (w_early_hb) begin
                    w_early_nxt = 1'b1;
                    w_trig_nxt  = 1'b1;
                    w_warn_nxt  = 1'b1;
                end else begin
                    // A good kick clears a timeout, but a trigger caused by an
                    // early kick stays until force_reset, disable or reconfig
                    w_trig_nxt = r_trig && r_early;
                    w_warn_nxt = r_trig && r_early;
                end
            end else if (r_cnt >= r_timeout) begin
                w_cnt_nxt  = r_timeout;
                w_trig_nxt = 1'b1;
                w_warn_nxt = 1'b1;
            end else begin
                w_cnt_nxt  = r_cnt + ONE;
                w_warn_nxt = (r_cnt >= w_warn_thr) || r_trig;
            end
        end

        // Channel state registers
        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_cnt     <= '0;
                r_timeout <= DEF_TO;
                r_window  <= '0;
                r_trig    <= 1'b0;
                r_warn    <= 1'b0;
                r_early   <= 1'b0;
            end else begin
                r_cnt     <= w_cnt_nxt;
                r_timeout <= w_timeout_nxt;
                r_window  <= w_window_nxt;
                r_trig    <= w_trig_nxt;
                r_warn    <= w_warn_nxt;
                r_early   <= w_early_nxt;
            end
        end

        assign w_trig_vec[g]  = r_trig;
        assign w_warn_vec[g]  = r_warn;
        assign w_early_vec[g] = r_early;

`ifdef FORMAL
        a_trig_warn: assert property (@(posedge clk) disable iff (!rstn)
            r_trig |-> r_warn);
        a_trig_cause: assert property (@(posedge clk) disable iff (!rstn)
            r_trig |-> ((r_cnt == r_timeout) || r_early));
        a_cnt_bound: assert property (@(posedge clk) disable iff (!rstn)
            r_cnt <= r_timeout);
        a_disable_clears: assert property (@(posedge clk) disable iff (!rstn)
            !bus.enable[g] |=> !(r_trig || r_warn || r_early));
        // Channels only see their own strobes; a foreign cfg write is inert here
        a_cfg_isolated: assert property (@(posedge clk) disable iff (!rstn)
            (bus.cfg_we && (bus.cfg_ch != CH_W'(g))) |=> ($stable(r_timeout) && $stable(r_window)));
        a_kick_isolated: assert property (@(posedge clk) disable iff (!rstn)
            (bus.enable[g] && !bus.force_reset[g] && !bus.heartbeat[g] && !w_cfg_hit
             && (r_cnt < r_timeout)) |=> (r_cnt == $past(r_cnt) + ONE));
`endif
    end

    // Population count of the registered triggered vector
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop = w_pop + POP_W'(w_trig_vec[i]);
        end
    end

    assign w_esc_nxt = (32'(w_pop) >= ESC_THRESHOLD);
    assign w_any_nxt = |w_trig_vec;

    // Global status, one cycle behind triggered
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_escalate <= 1'b0;
            r_any      <= 1'b0;
        end else begin
            r_escalate <= w_esc_nxt;
            r_any      <= w_any_nxt;
        end
    end

    assign bus.triggered     = w_trig_vec;
    assign bus.warning       = w_warn_vec;
    assign bus.early_err     = w_early_vec;
    assign bus.escalate      = r_escalate;
    assign bus.any_triggered = r_any;
endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Self-checking bench for multi_channel_watchdog: a table of directed vectors,
// hand-written corner sequences, and a random run against an age-based model.
module tb_multi_channel_watchdog;
    localparam int unsigned NCH    = 5;
    localparam int unsigned CW     = 16;
    localparam int unsigned CHW    = 3;
    localparam int unsigned DEF_TO = 40;
    localparam int unsigned WSH    = 2;
    localparam bit          WIN_EN = 1'b1;
    localparam int unsigned ESC_T  = 2;

    typedef struct {
        int             n_cyc;
        logic [NCH-1:0] en;
        logic [NCH-1:0] hb;
        logic [NCH-1:0] fr;
        logic           we;
        int             ch;
        int             to;
        int             win;
        logic [NCH-1:0] e_trig;
        logic [NCH-1:0] e_warn;
        logic [NCH-1:0] e_early;
        logic           e_esc;
        logic           e_any;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;

    // Model: each channel is described by its age (edges since its last
    // clearing event); counter, warning and timeout follow from the age.
    int m_to   [NCH];
    int m_win  [NCH];
    int m_age  [NCH];
    bit m_early[NCH];
    bit m_etrig[NCH];
    bit m_esc;
    bit m_any;

    vec_t tbl[8];

    always #5 clk = ~clk;

    multi_channel_watchdog_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    multi_channel_watchdog #(
        .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_TIMEOUT(DEF_TO),
        .WARN_SHIFT(WSH), .WINDOW_EN(WIN_EN), .ESC_THRESHOLD(ESC_T)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    function automatic bit m_trig(input int i);
        return m_etrig[i] || (m_age[i] > m_to[i]);
    endfunction

    function automatic bit m_warn(input int i);
        int thr;
        thr = m_to[i] - (m_to[i] >> WSH);
        return m_trig(i) || (m_age[i] > thr);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_to[i]    = int'(DEF_TO);
            m_win[i]   = 0;
            m_age[i]   = 0;
            m_early[i] = 1'b0;
            m_etrig[i] = 1'b0;
        end
        m_esc = 1'b0;
        m_any = 1'b0;
    endtask

    task automatic model_step();
        int pop;
        int cnt;
        bit tr[NCH];
        pop = 0;
        for (int i = 0; i < NCH; i++) begin
            tr[i] = m_trig(i);
            pop += int'(tr[i]);
        end
        if (!rstn) begin
            model_reset();
            return;
        end
        m_esc = (pop >= int'(ESC_T));
        m_any = (pop > 0);
        for (int i = 0; i < NCH; i++) begin
            if (!bus.enable[i] || bus.force_reset[i]) begin
                m_age[i]   = 0;
                m_etrig[i] = 1'b0;
                m_early[i] = 1'b0;
            end else if (bus.cfg_we && (int'(bus.cfg_ch) == i)) begin
                m_to[i]    = (bus.cfg_timeout == '0) ? 1 : int'(bus.cfg_timeout);
                m_win[i]   = (int'(bus.cfg_window) >= m_to[i]) ? 0 : int'(bus.cfg_window);
                m_age[i]   = 0;
                m_etrig[i] = 1'b0;
            end else if (bus.heartbeat[i]) begin
                cnt = (m_age[i] < m_to[i]) ? m_age[i] : m_to[i];
                if (WIN_EN && (cnt < m_win[i])) begin
                    m_early[i] = 1'b1;
                    m_etrig[i] = 1'b1;
                end else begin
                    m_etrig[i] = tr[i] && m_early[i];
                end
                m_age[i] = 0;
            end else begin
                m_age[i]++;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [NCH-1:0] et;
        logic [NCH-1:0] ew;
        logic [NCH-1:0] ee;
        for (int i = 0; i < NCH; i++) begin
            et[i] = m_trig(i);
            ew[i] = m_warn(i);
            ee[i] = m_early[i];
        end
        check("model_triggered", 32'(bus.triggered), 32'(et));
        check("model_warning",   32'(bus.warning),   32'(ew));
        check("model_early_err", 32'(bus.early_err), 32'(ee));
        check("model_escalate",  32'(bus.escalate),  32'(m_esc));
        check("model_any_trig",  32'(bus.any_triggered), 32'(m_any));
    endtask

    // One clock: model advances on the same edge, outputs sampled 1 ns later
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic drive(input logic [NCH-1:0] en, input logic [NCH-1:0] hb,
                         input logic [NCH-1:0] fr, input logic we,
                         input int ch, input int to, input int win);
        bus.enable      = en;
        bus.heartbeat   = hb;
        bus.force_reset = fr;
        bus.cfg_we      = we;
        bus.cfg_ch      = CHW'(ch);
        bus.cfg_timeout = CW'(to);
        bus.cfg_window  = CW'(win);
    endtask

    task automatic idle(input logic [NCH-1:0] en);
        drive(en, '0, '0, 1'b0, 0, 0, 0);
    endtask

    // Run idle cycles until triggered[ch] is seen; n is the edge count
    task automatic wait_trig(input int ch, input int limit, output int n);
        n = 0;
        while (!bus.triggered[ch] && (n < limit)) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: bench still running at %0t", $time);
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        logic [NCH-1:0] r_en;
        logic [NCH-1:0] r_hb;
        logic [NCH-1:0] r_fr;

        //            n  en        hb     fr     we    ch to  win  trig      warn      early  esc   any
        tbl[0] = '{1, 5'b00001, 5'b0, 5'b0, 1'b1, 0, 10, 0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b0};
        tbl[1] = '{8, 5'b00001, 5'b0, 5'b0, 1'b0, 0, 0,  0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b0};
        tbl[2] = '{1, 5'b00001, 5'b0, 5'b0, 1'b0, 0, 0,  0, 5'b00000, 5'b00001, 5'b0, 1'b0, 1'b0};
        tbl[3] = '{1, 5'b00001, 5'b0, 5'b0, 1'b0, 0, 0,  0, 5'b00000, 5'b00001, 5'b0, 1'b0, 1'b0};
        tbl[4] = '{1, 5'b00001, 5'b0, 5'b0, 1'b0, 0, 0,  0, 5'b00001, 5'b00001, 5'b0, 1'b0, 1'b0};
        tbl[5] = '{1, 5'b00001, 5'b0, 5'b0, 1'b0, 0, 0,  0, 5'b00001, 5'b00001, 5'b0, 1'b0, 1'b1};
        tbl[6] = '{1, 5'b00000, 5'b0, 5'b0, 1'b0, 0, 0,  0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b1};
        tbl[7] = '{1, 5'b00000, 5'b0, 5'b0, 1'b0, 0, 0,  0, 5'b00000, 5'b00000, 5'b0, 1'b0, 1'b0};

        model_reset();
        rstn = 1'b0;
        idle('0);
        cycle();
        cycle();
        check("reset_triggered", 32'(bus.triggered), 32'd0);
        check("reset_warning",   32'(bus.warning),   32'd0);
        check("reset_early_err", 32'(bus.early_err), 32'd0);
        check("reset_escalate",  32'(bus.escalate),  32'd0);
        check("reset_any",       32'(bus.any_triggered), 32'd0);
        rstn = 1'b1;

        // Channel 0, timeout 10: warning, trigger, lagging any_triggered
        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].en, tbl[k].hb, tbl[k].fr, tbl[k].we, tbl[k].ch, tbl[k].to, tbl[k].win);
            cycle();
            idle(tbl[k].en);
            for (int c = 1; c < tbl[k].n_cyc; c++) cycle();
            check($sformatf("vec%0d_triggered", k), 32'(bus.triggered), 32'(tbl[k].e_trig));
            check($sformatf("vec%0d_warning", k),   32'(bus.warning),   32'(tbl[k].e_warn));
            check($sformatf("vec%0d_early_err", k), 32'(bus.early_err), 32'(tbl[k].e_early));
            check($sformatf("vec%0d_escalate", k),  32'(bus.escalate),  32'(tbl[k].e_esc));
            check($sformatf("vec%0d_any", k),       32'(bus.any_triggered), 32'(tbl[k].e_any));
        end

        // Channel 1 kicked every 9 cycles with timeout 10 never warns
        drive(5'b00010, '0, '0, 1'b1, 1, 10, 0);
        cycle();
        for (int k = 1; k <= 200; k++) begin
            drive(5'b00010, ((k % 9) == 0) ? 5'b00010 : 5'b00000, '0, 1'b0, 0, 0, 0);
            cycle();
            check("kick9_ch1_flags", 32'({bus.triggered[1], bus.warning[1]}), 32'd0);
        end

        // Window violation on channel 2, sticky across a good kick
        drive(5'b00100, '0, '0, 1'b1, 2, 20, 5);
        cycle();
        idle(5'b00100);
        repeat (3) cycle();
        drive(5'b00100, 5'b00100, '0, 1'b0, 0, 0, 0);
        cycle();
        check("early_kick_flags", 32'({bus.early_err[2], bus.triggered[2], bus.warning[2]}), 32'b111);
        idle(5'b00100);
        repeat (6) cycle();
        drive(5'b00100, 5'b00100, '0, 1'b0, 0, 0, 0);
        cycle();
        check("good_kick_keeps", 32'({bus.early_err[2], bus.triggered[2]}), 32'b11);
        drive(5'b00100, '0, 5'b00100, 1'b0, 0, 0, 0);
        cycle();
        check("force_clears_ch2", 32'({bus.early_err[2], bus.triggered[2], bus.warning[2]}), 32'd0);

        // Channels 0 and 3 time out; escalate follows triggered by one cycle
        drive(5'b01001, '0, '0, 1'b1, 0, 10, 0);
        cycle();
        drive(5'b01001, '0, '0, 1'b1, 3, 12, 0);
        cycle();
        idle(5'b01001);
        wait_trig(3, 40, n);
        check("ch3_latency", 32'(n), 32'd13);
        check("esc_lag_low", 32'(bus.escalate), 32'd0);
        cycle();
        check("esc_rise", 32'(bus.escalate), 32'd1);
        drive(5'b01001, '0, 5'b00001, 1'b0, 0, 0, 0);
        cycle();
        check("force0_trig", 32'(bus.triggered[0]), 32'd0);
        check("esc_still_high", 32'(bus.escalate), 32'd1);
        idle(5'b01001);
        cycle();
        check("esc_fall", 32'(bus.escalate), 32'd0);
        check("any_held", 32'(bus.any_triggered), 32'd1);

        // force_reset beats heartbeat and cfg write on the same channel
        drive(5'b00110, 5'b00010, 5'b00010, 1'b1, 1, 3, 0);
        cycle();
        check("collide_ch1_flags", 32'({bus.triggered[1], bus.warning[1], bus.early_err[1]}), 32'd0);
        idle(5'b00110);
        wait_trig(1, 30, n);
        check("ch1_cfg_lost", 32'(n), 32'd11);
        drive(5'b00110, '0, 5'b00010, 1'b1, 2, 4, 0);
        cycle();
        idle(5'b00110);
        wait_trig(2, 30, n);
        check("ch2_cfg_done", 32'(n), 32'd5);

        // Zero timeout clamps to one; out-of-range channel write is inert
        drive(5'b10110, '0, '0, 1'b1, 4, 0, 0);
        cycle();
        idle(5'b10110);
        wait_trig(4, 10, n);
        check("clamp_latency", 32'(n), 32'd2);
        drive(5'b10110, '0, '0, 1'b1, 5, 3, 0);
        cycle();
        check("oor_ch4_trig", 32'(bus.triggered[4]), 32'd1);
        idle(5'b10110);
        cycle();

        // Reset mid-count restores the default timeout
        rstn = 1'b0;
        cycle();
        check("midrst_triggered", 32'(bus.triggered), 32'd0);
        check("midrst_warning",   32'(bus.warning),   32'd0);
        check("midrst_escalate",  32'(bus.escalate),  32'd0);
        check("midrst_any",       32'(bus.any_triggered), 32'd0);
        rstn = 1'b1;
        idle(5'b00001);
        wait_trig(0, 60, n);
        check("default_latency", 32'(n), 32'(DEF_TO + 1));

        // Random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < NCH; i++) begin
                r_en[i] = ($urandom_range(0, 15) != 0);
                r_hb[i] = ($urandom_range(0, 7) == 0);
                r_fr[i] = ($urandom_range(0, 63) == 0);
            end
            rstn = ($urandom_range(0, 199) != 0);
            drive(r_en, r_hb, r_fr, ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 20)),
                  int'($urandom_range(0, 20)));
            cycle();
        end
        rstn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
